// File: rtl/step_control_unit.sv
// Board-input front end: synchronises and debounces the step button and run switch,
// and issues a one-cycle StepEn either per button press (step mode) or at a divided rate (run mode).
module step_control_unit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 100000000,
  parameter int CNT_W           = 27
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnStep,
  input  logic        SwRun,
  output logic        StepEn,
  output logic        BtnClean,
  output logic        RunMode,
  output logic [15:0] StepCount
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RUN_DIV - 1);

  // Returns {next_clean, next_count}; any agreement with the clean level restarts the count.
  function automatic logic [CNT_W:0] debounce_next(input logic             synced,
                                                   input logic             clean,
                                                   input logic [CNT_W-1:0] cnt);
    logic [CNT_W:0] res;
    if (synced == clean) begin
      res = {clean, {CNT_W{1'b0}}};
    end else if (cnt == DB_LAST) begin
      res = {~clean, {CNT_W{1'b0}}};
    end else begin
      res = {clean, cnt + CNT_W'(1)};
    end
    return res;
  endfunction

  logic [1:0]       btn_sync_r;
  logic [1:0]       sw_sync_r;
  logic [CNT_W-1:0] btn_cnt_r;
  logic [CNT_W-1:0] sw_cnt_r;
  logic             btn_clean_r;
  logic             run_mode_r;
  logic             btn_prev_r;
  state_t           state_r;
  logic [CNT_W-1:0] rate_cnt_r;
  logic             step_en_r;
  logic [15:0]      step_count_r;

  logic             btn_clean_s;
  logic [CNT_W-1:0] btn_cnt_s;
  logic             sw_clean_s;
  logic [CNT_W-1:0] sw_cnt_s;
  logic             rise_s;
  logic             rate_hit_s;

  // Next-state for both debouncers plus edge and rate-terminal decodes.
  always_comb begin
    {btn_clean_s, btn_cnt_s} = debounce_next(btn_sync_r[1], btn_clean_r, btn_cnt_r);
    {sw_clean_s, sw_cnt_s}   = debounce_next(sw_sync_r[1], run_mode_r, sw_cnt_r);
    rise_s     = btn_clean_r & ~btn_prev_r;
    rate_hit_s = run_mode_r & (rate_cnt_r == RATE_LAST);
  end

  // Two-flop synchronisers and debounce state for both raw inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_sync_r  <= 2'b00;
      sw_sync_r   <= 2'b00;
      btn_cnt_r   <= {CNT_W{1'b0}};
      sw_cnt_r    <= {CNT_W{1'b0}};
      btn_clean_r <= 1'b0;
      run_mode_r  <= 1'b0;
    end else begin
      btn_sync_r  <= {btn_sync_r[0], BtnStep};
      sw_sync_r   <= {sw_sync_r[0], SwRun};
      btn_cnt_r   <= btn_cnt_s;
      sw_cnt_r    <= sw_cnt_s;
      btn_clean_r <= btn_clean_s;
      run_mode_r  <= sw_clean_s;
    end
  end

  // Run-mode rate divider; parked at zero outside run mode so an exit mid-count never fires.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rate_cnt_r <= {CNT_W{1'b0}};
    end else if (!run_mode_r) begin
      rate_cnt_r <= {CNT_W{1'b0}};
    end else if (rate_hit_s) begin
      rate_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rate_cnt_r <= rate_cnt_r + CNT_W'(1);
    end
  end

  // Press/release FSM and the registered StepEn; the FSM tracks the button even in run mode.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      btn_prev_r <= 1'b0;
      step_en_r  <= 1'b0;
    end else begin
      btn_prev_r <= btn_clean_r;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= WAIT_REL;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_REL: begin
          if (!btn_clean_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_REL;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (run_mode_r) begin
        step_en_r <= rate_hit_s;
      end else begin
        step_en_r <= (state_r == IDLE) & rise_s;
      end
    end
  end

  // Wrapping count of issued steps for the display path.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_count_r <= 16'h0000;
    end else if (step_en_r) begin
      step_count_r <= step_count_r + 16'h0001;
    end else begin
      step_count_r <= step_count_r;
    end
  end

  assign StepEn    = step_en_r;
  assign BtnClean  = btn_clean_r;
  assign RunMode   = run_mode_r;
  assign StepCount = step_count_r;

endmodule

// File: tb/tb_step_control_unit.sv
// Self-checking bench for step_control_unit with small debounce/rate constants:
// table-driven step-mode presses, run-mode phases, counter wrap and async reset.
module tb_step_control_unit;

  logic        Clk;
  logic        Reset;
  logic        BtnStep;
  logic        SwRun;
  logic        StepEn;
  logic        BtnClean;
  logic        RunMode;
  logic [15:0] StepCount;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_q[$];
  logic [15:0] exp_count;

  typedef struct {
    int hold;
    bit bounce;
    bit exp_pulse;
  } vec_t;

  vec_t vecs[5];

  step_control_unit #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(5),
    .CNT_W(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .BtnStep(BtnStep),
    .SwRun(SwRun),
    .StepEn(StepEn),
    .BtnClean(BtnClean),
    .RunMode(RunMode),
    .StepCount(StepCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Scoreboard: pops expected pulse cycles and checks StepEn timing and StepCount.
  task automatic monitor();
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge Clk);
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: none at cycle %0d, expected one", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (StepEn) begin
        n_checks++;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
          check("count_at_pulse", 32'(StepCount), 32'(exp_count));
          exp_count = exp_count + 16'h0001;
        end else begin
          n_fail++;
          $display("FAIL unexpected_pulse: StepEn=1 at cycle %0d, expected 0", cyc);
        end
        if (prev_en) begin
          n_checks++;
          n_fail++;
          $display("FAIL double_pulse: StepEn high two cycles at %0d, expected 1 cycle", cyc);
        end
      end
      prev_en = StepEn;
    end
  endtask

  task automatic press(input int hold, input bit bounce, input bit exp_pulse);
    int t;
    int r;
    if (bounce) begin
      for (int i = 0; i < 4; i++) begin
        BtnStep = (i % 2 == 0) ? 1'b1 : 1'b0;
        tick(2);
        check("clean_low_in_bounce", 32'(BtnClean), 32'd0);
      end
    end
    t = cyc;
    BtnStep = 1'b1;
    if (exp_pulse) exp_q.push_back(t + 7);
    tick(hold);
    BtnStep = 1'b0;
    r = cyc;
    if (exp_pulse) begin
      wait_until(r + 5);
      check("clean_before_fall", 32'(BtnClean), 32'd1);
      wait_until(r + 6);
      check("clean_fall", 32'(BtnClean), 32'd0);
    end else begin
      wait_until(r + 6);
      check("clean_stays_low", 32'(BtnClean), 32'd0);
    end
    tick(6);
    check("queue_empty_press", 32'(exp_q.size()), 32'd0);
    check("count_after_press", 32'(StepCount), 32'(exp_count));
  endtask

  // Run mode for n+1 pulses, then SwRun drops so RunMode falls with the rate counter at 3.
  task automatic run_phase(input int n, input bit do_press);
    int k;
    int p;
    k = cyc;
    p = k + 11 + 5 * n;
    SwRun = 1'b1;
    for (int i = 0; i <= n; i++) exp_q.push_back(k + 11 + 5 * i);
    if (do_press) begin
      wait_until(k + 2);
      BtnStep = 1'b1;
    end
    wait_until(k + 5);
    check("runmode_not_yet", 32'(RunMode), 32'd0);
    wait_until(k + 6);
    check("runmode_rise", 32'(RunMode), 32'd1);
    if (do_press) begin
      wait_until(k + 10);
      BtnStep = 1'b0;
    end
    wait_until(p - 3);
    SwRun = 1'b0;
    wait_until(p + 3);
    check("runmode_fall", 32'(RunMode), 32'd0);
    check("rate_at_exit", 32'(dut.rate_cnt_r), 32'd3);
    wait_until(p + 4);
    check("rate_held_zero", 32'(dut.rate_cnt_r), 32'd0);
    wait_until(p + 15);
    check("queue_empty_run", 32'(exp_q.size()), 32'd0);
    check("count_after_run", 32'(StepCount), 32'(exp_count));
  endtask

  initial begin
    int t;
    int r;
    vecs[0] = '{hold: 20, bounce: 1'b0, exp_pulse: 1'b1};
    vecs[1] = '{hold: 20, bounce: 1'b1, exp_pulse: 1'b1};
    vecs[2] = '{hold: 3,  bounce: 1'b0, exp_pulse: 1'b0};
    vecs[3] = '{hold: 4,  bounce: 1'b0, exp_pulse: 1'b1};
    vecs[4] = '{hold: 1,  bounce: 1'b0, exp_pulse: 1'b0};

    Reset     = 1'b1;
    BtnStep   = 1'b0;
    SwRun     = 1'b0;
    exp_count = 16'h0000;
    fork
      monitor();
    join_none

    tick(3);
    check("reset_stepen", 32'(StepEn), 32'd0);
    check("reset_btnclean", 32'(BtnClean), 32'd0);
    check("reset_runmode", 32'(RunMode), 32'd0);
    check("reset_stepcount", 32'(StepCount), 32'd0);
    Reset = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) begin
      press(vecs[i].hold, vecs[i].bounce, vecs[i].exp_pulse);
    end

    run_phase(6, 1'b1);
    press(20, 1'b0, 1'b1);

    // Preload the counter just below the wrap point.
    @(negedge Clk);
    force dut.step_count_r = 16'hFFFE;
    @(posedge Clk);
    #1;
    release dut.step_count_r;
    exp_count = 16'hFFFE;
    tick(1);
    check("preload", 32'(StepCount), 32'h0000FFFE);
    run_phase(2, 1'b0);
    check("wrapped_count", 32'(StepCount), 32'h00000001);

    // Async reset while the button is held and the FSM waits for release.
    t = cyc;
    BtnStep = 1'b1;
    exp_q.push_back(t + 7);
    tick(10);
    check("held_clean", 32'(BtnClean), 32'd1);
    check("held_state", 32'(dut.state_r), 32'd1);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async_stepen", 32'(StepEn), 32'd0);
    check("async_btnclean", 32'(BtnClean), 32'd0);
    check("async_runmode", 32'(RunMode), 32'd0);
    check("async_stepcount", 32'(StepCount), 32'd0);
    exp_count = 16'h0000;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    r = cyc;
    exp_q.push_back(r + 7);
    tick(12);
    check("queue_empty_reset", 32'(exp_q.size()), 32'd0);
    check("count_after_reset", 32'(StepCount), 32'd1);
    BtnStep = 1'b0;
    tick(12);
    check("queue_empty_final", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
